speed_ctrl: RTL and testbench
=============================

Name: speed_ctrl

Overview:
- Control FSM that sits directly upstream of the speed/barrier datapath and drives its init/count/cal/up/down/en/dis strobes.
- Watches two entry sensors a fixed distance apart and one exit sensor.
- Sequences timing and the speed divide, then decides whether the barrier opens, using the returned speed, done and num_veh.

Parameters:
- WIDTH_SPEED, 14, width of the speed input; matches the datapath.
- SPEED_LIMIT, 60, maximum admitted speed (km/h); admit when speed <= SPEED_LIMIT.
- MAX_VEH, 3, lot capacity; admit only when num_veh < MAX_VEH.
- TIMEOUT_CYC, 100000000, cycles allowed between sen1 and sen2 edges (2 s at 50 MHz).
- OPEN_CYC, 150000000, cycles the barrier is held open (3 s at 50 MHz).
- WIDTH_CNT, 28, width of the internal cycle counter; must hold max(TIMEOUT_CYC, OPEN_CYC).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  synchronous, active-high reset (1 = reset), sampled on rising clk.
- sen1  in  1  asynchronous entry sensor A (first crossed).
- sen2  in  1  asynchronous entry sensor B (second crossed).
- sen_exit  in  1  asynchronous exit sensor.
- done  in  1  divider-complete flag from the datapath.
- speed  in  WIDTH_SPEED  computed speed from the datapath; valid while done=1.
- num_veh  in  2  current vehicle count from the datapath.
- init  out  1  clear the datapath timers/divider.
- count  out  1  advance the datapath tick counter.
- cal  out  1  start the divide.
- up  out  1  one-cycle pulse: vehicle admitted.
- down  out  1  one-cycle pulse: vehicle left.
- en  out  1  barrier-open request.
- dis  out  1  barrier-close request.
- reject  out  1  one-cycle pulse: vehicle refused (too fast, lot full, or timeout).
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset
  - Single clock; reset_n is synchronous and active-high.
  - While reset_n=1: state=IDLE, counter=0, synchronizer flops=0, and every output is 0.
- Input conditioning
  - Each sensor passes through a 2-flop synchronizer plus one delay flop: edge = s2 & ~s3.
  - A level first sampled high at edge k produces an edge pulse in the cycle after edge k+2; the FSM acts at edge k+3.
  - Levels that stay high never re-trigger.
- Output timing
  - All outputs are registered and decoded from next_state, so they are valid in the same cycle as the state they belong to.
- States
  - IDLE: init=1.
    - sen1 edge → TIMING; counter cleared.
    - A sen2 edge without a prior sen1 edge is ignored.
  - TIMING: count=1; counter increments each cycle.
    - sen2 edge → CALC.
    - Counter reaches TIMEOUT_CYC-1 with no sen2 edge → IDLE; reject pulse.
    - A sen2 edge on the timeout cycle takes priority and goes to CALC.
    - Further sen1 edges are ignored.
  - CALC: cal=1 for exactly the entry cycle, then 0.
    - Hold until done=1 → DECIDE. There is no timeout here.
  - DECIDE: one cycle; speed and num_veh are sampled.
    - speed <= SPEED_LIMIT and num_veh < MAX_VEH → OPEN; up=1 and en=1 on the entry cycle; counter cleared.
    - Otherwise → IDLE; reject=1 and dis=1 for one cycle.
    - speed=0 (divide by zero or overflow) counts as a fail.
  - OPEN: en=1 held.
    - Counter reaches OPEN_CYC-1 → CLOSE.
  - CLOSE: dis=1 for one cycle, en=0 → IDLE.
- Exit path (independent of the FSM)
  - sen_exit edge with num_veh != 0 → down=1 for one cycle.
  - sen_exit edge with num_veh = 0 → no pulse (no underflow).
  - down may coincide with up; both pulses are still issued, and the datapath nets the pair to no change.
- Invariants and mid-operation reset
  - up never asserts when num_veh = MAX_VEH.
  - en and dis are never both 1.
  - Reset asserted in any state returns to IDLE at the next edge with all outputs 0.

Test Plan (sim parameters TIMEOUT_CYC=1000, OPEN_CYC=20, SPEED_LIMIT=60, MAX_VEH=3):
- Reset: hold reset_n=1 for 3 cycles, then release → all outputs 0 during reset; init=1 from the first post-reset edge; busy=0.
- Admit: sen1 rises, sen2 rises 200 cycles later; done=1 with speed=40 and num_veh=0 → TIMING ~200 cycles; cal high 1 cycle; one up pulse; en high 20 cycles; one dis pulse; back to IDLE.
- Speeding: same sequence with speed=144 → no up, no en; reject=1 and dis=1 for one cycle; IDLE.
- Full lot: speed=30 with num_veh=3 → reject pulse; up stays 0.
- Timeout: sen1 edge with no sen2 → after 1000 cycles in TIMING, reject pulse and IDLE; a later lone sen2 edge is ignored.
- Exit and collision:
  - sen_exit edge with num_veh=2 → one down pulse.
  - sen_exit edge with num_veh=0 → no pulse.
  - Exit edge timed to the admit cycle → up and down both pulse in the same cycle.
  - reset_n=1 during OPEN → en=0 at the next edge; state IDLE.

Source files
------------

// File: rtl/speed_ctrl.sv
// rtl/speed_ctrl.sv - entry/exit control FSM driving the speed datapath and barrier strobes
module speed_ctrl #(
    parameter int WIDTH_SPEED = 14,
    parameter int SPEED_LIMIT = 60,
    parameter int MAX_VEH     = 3,
    parameter int TIMEOUT_CYC = 100000000,
    parameter int OPEN_CYC    = 150000000,
    parameter int WIDTH_CNT   = 28
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sen1,
    input  logic                   sen2,
    input  logic                   sen_exit,
    input  logic                   done,
    input  logic [WIDTH_SPEED-1:0] speed,
    input  logic [1:0]             num_veh,
    output logic                   init,
    output logic                   count,
    output logic                   cal,
    output logic                   up,
    output logic                   down,
    output logic                   en,
    output logic                   dis,
    output logic                   reject,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TIMING = 3'd1,
        S_CALC   = 3'd2,
        S_DECIDE = 3'd3,
        S_OPEN   = 3'd4,
        S_CLOSE  = 3'd5
    } state_t;

    localparam logic [WIDTH_CNT-1:0]   C_TIMEOUT_LAST = WIDTH_CNT'(TIMEOUT_CYC - 1);
    localparam logic [WIDTH_CNT-1:0]   C_OPEN_LAST    = WIDTH_CNT'(OPEN_CYC - 1);
    localparam logic [WIDTH_CNT-1:0]   C_CNT_ONE      = WIDTH_CNT'(1);
    localparam logic [WIDTH_SPEED-1:0] C_SPEED_LIMIT  = WIDTH_SPEED'(SPEED_LIMIT);
    localparam logic [2:0]             C_MAX_VEH      = 3'(MAX_VEH);

    state_t                 r_state;
    state_t                 w_next;
    logic [WIDTH_CNT-1:0]   r_cnt;

    // bit0/bit1 form the synchronizer, bit2 is the delay flop used for edge detection
    logic [2:0]             r_sen1_sh;
    logic [2:0]             r_sen2_sh;
    logic [2:0]             r_exit_sh;
    logic                   r_sen1_edge;
    logic                   r_sen2_edge;
    logic                   r_exit_edge;

    logic                   w_admit;

    logic                   r_init;
    logic                   r_count;
    logic                   r_cal;
    logic                   r_up;
    logic                   r_down;
    logic                   r_en;
    logic                   r_dis;
    logic                   r_reject;
    logic                   r_busy;

    // A zero speed means the divide failed (divide by zero or overflow), so it never admits
    assign w_admit = (speed != '0) && (speed <= C_SPEED_LIMIT) && ({1'b0, num_veh} < C_MAX_VEH);

    // Synchronize the three sensors and register a one-cycle rising-edge pulse for each
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_sen1_sh   <= '0;
            r_sen2_sh   <= '0;
            r_exit_sh   <= '0;
            r_sen1_edge <= 1'b0;
            r_sen2_edge <= 1'b0;
            r_exit_edge <= 1'b0;
        end else begin
            r_sen1_sh   <= {r_sen1_sh[1:0], sen1};
            r_sen2_sh   <= {r_sen2_sh[1:0], sen2};
            r_exit_sh   <= {r_exit_sh[1:0], sen_exit};
            r_sen1_edge <= r_sen1_sh[1] & ~r_sen1_sh[2];
            r_sen2_edge <= r_sen2_sh[1] & ~r_sen2_sh[2];
            r_exit_edge <= r_exit_sh[1] & ~r_exit_sh[2];
        end
    end

    // Next-state decode; a sen2 edge on the timeout cycle still wins over the timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_sen1_edge) begin
                    w_next = S_TIMING;
                end
            end
            S_TIMING: begin
                if (r_sen2_edge) begin
                    w_next = S_CALC;
                end else if (r_cnt == C_TIMEOUT_LAST) begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (done) begin
                    w_next = S_DECIDE;
                end
            end
            S_DECIDE: begin
                w_next = w_admit ? S_OPEN : S_IDLE;
            end
            S_OPEN: begin
                if (r_cnt == C_OPEN_LAST) begin
                    w_next = S_CLOSE;
                end
            end
            S_CLOSE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, cycle counter and strobes, all decoded from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_init   <= 1'b0;
            r_count  <= 1'b0;
            r_cal    <= 1'b0;
            r_up     <= 1'b0;
            r_en     <= 1'b0;
            r_dis    <= 1'b0;
            r_reject <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_TIMING) || (r_state == S_OPEN)) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
            r_init   <= (w_next == S_IDLE);
            r_count  <= (w_next == S_TIMING);
            r_cal    <= (w_next == S_CALC) && (r_state != S_CALC);
            r_up     <= (r_state == S_DECIDE) && (w_next == S_OPEN);
            r_en     <= (w_next == S_OPEN);
            r_dis    <= (w_next == S_CLOSE) || ((r_state == S_DECIDE) && (w_next == S_IDLE));
            r_reject <= ((r_state == S_TIMING) || (r_state == S_DECIDE)) && (w_next == S_IDLE);
            r_busy   <= (w_next != S_IDLE);
        end
    end

    // Exit path runs beside the FSM; an empty lot never produces a down pulse
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_down <= 1'b0;
        end else begin
            r_down <= r_exit_edge && (num_veh != 2'd0);
        end
    end

    assign init   = r_init;
    assign count  = r_count;
    assign cal    = r_cal;
    assign up     = r_up;
    assign down   = r_down;
    assign en     = r_en;
    assign dis    = r_dis;
    assign reject = r_reject;
    assign busy   = r_busy;

endmodule

// File: tb/tb_speed_ctrl.sv
// tb/tb_speed_ctrl.sv - self-checking bench for speed_ctrl
module tb_speed_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        sen1 = 1'b0;
    logic        sen2 = 1'b0;
    logic        sen_exit = 1'b0;
    logic        done = 1'b0;
    logic [13:0] speed = '0;
    logic [1:0]  num_veh = '0;
    logic        init, count, cal, up, down, en, dis, reject, busy;

    int checks = 0;
    int errors = 0;
    int n_count, n_cal, n_up, n_down, n_en, n_dis, n_rej, n_busy, n_both;
    int n_endis_total = 0;
    int n_up_full_total = 0;

    typedef struct {
        int          gap;
        logic [13:0] spd;
        logic [1:0]  nv;
        int          exp_up;
        int          exp_en;
        int          exp_dis;
        int          exp_rej;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    speed_ctrl #(
        .WIDTH_SPEED(14),
        .SPEED_LIMIT(60),
        .MAX_VEH(3),
        .TIMEOUT_CYC(1000),
        .OPEN_CYC(20),
        .WIDTH_CNT(28)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sen1(sen1),
        .sen2(sen2),
        .sen_exit(sen_exit),
        .done(done),
        .speed(speed),
        .num_veh(num_veh),
        .init(init),
        .count(count),
        .cal(cal),
        .up(up),
        .down(down),
        .en(en),
        .dis(dis),
        .reject(reject),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_count = 0; n_cal = 0; n_up = 0; n_down = 0; n_en = 0;
        n_dis = 0; n_rej = 0; n_busy = 0; n_both = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n_count += int'(count);
        n_cal   += int'(cal);
        n_up    += int'(up);
        n_down  += int'(down);
        n_en    += int'(en);
        n_dis   += int'(dis);
        n_rej   += int'(reject);
        n_busy  += int'(busy);
        n_both  += int'(up & down);
        n_endis_total   += int'(en & dis);
        n_up_full_total += int'(up & (num_veh == 2'd3));
    endtask

    task automatic run_vehicle(input int gap, input logic [13:0] spd, input logic [1:0] nv,
                               input int done_dly, input bit with_exit);
        int guard;
        clear_counts();
        sen1 = 1'b1;
        repeat (gap) step();
        sen2 = 1'b1;
        guard = 0;
        while (!cal && guard < 50) begin
            step();
            guard++;
        end
        check("cal_reached", 32'(cal), 32'd1);
        if (with_exit) sen_exit = 1'b1;
        repeat (done_dly) step();
        done = 1'b1;
        speed = spd;
        num_veh = nv;
        guard = 0;
        while (busy && guard < 100) begin
            step();
            guard++;
        end
        check("back_to_idle", 32'(busy), 32'd0);
        sen1 = 1'b0;
        sen2 = 1'b0;
        sen_exit = 1'b0;
        done = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        int guard;

        vecs[0] = '{gap: 200, spd: 14'd40,  nv: 2'd0, exp_up: 1, exp_en: 20, exp_dis: 1, exp_rej: 0};
        vecs[1] = '{gap: 200, spd: 14'd144, nv: 2'd0, exp_up: 0, exp_en: 0,  exp_dis: 1, exp_rej: 1};
        vecs[2] = '{gap: 200, spd: 14'd30,  nv: 2'd3, exp_up: 0, exp_en: 0,  exp_dis: 1, exp_rej: 1};
        vecs[3] = '{gap: 37,  spd: 14'd60,  nv: 2'd2, exp_up: 1, exp_en: 20, exp_dis: 1, exp_rej: 0};
        vecs[4] = '{gap: 12,  spd: 14'd61,  nv: 2'd0, exp_up: 0, exp_en: 0,  exp_dis: 1, exp_rej: 1};
        vecs[5] = '{gap: 25,  spd: 14'd0,   nv: 2'd0, exp_up: 0, exp_en: 0,  exp_dis: 1, exp_rej: 1};
        vecs[6] = '{gap: 5,   spd: 14'd1,   nv: 2'd2, exp_up: 1, exp_en: 20, exp_dis: 1, exp_rej: 0};

        // reset held for three cycles
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_outputs_zero", 32'({init, count, cal, up, down, en, dis, reject, busy}), 32'd0);
        end
        reset_n = 1'b0;
        step();
        check("post_reset_init", 32'(init), 32'd1);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_count", 32'(count), 32'd0);
        repeat (4) step();

        // decision table
        for (int v = 0; v < 7; v++) begin
            run_vehicle(vecs[v].gap, vecs[v].spd, vecs[v].nv, 0, 1'b0);
            check($sformatf("v%0d_timing_cycles", v), 32'(n_count), 32'(vecs[v].gap));
            check($sformatf("v%0d_cal_pulses", v), 32'(n_cal), 32'd1);
            check($sformatf("v%0d_up", v), 32'(n_up), 32'(vecs[v].exp_up));
            check($sformatf("v%0d_en_cycles", v), 32'(n_en), 32'(vecs[v].exp_en));
            check($sformatf("v%0d_dis", v), 32'(n_dis), 32'(vecs[v].exp_dis));
            check($sformatf("v%0d_reject", v), 32'(n_rej), 32'(vecs[v].exp_rej));
        end

        // timeout: sen1 without sen2
        clear_counts();
        sen1 = 1'b1;
        guard = 0;
        while (!reject && guard < 1100) begin
            step();
            guard++;
        end
        check("timeout_reject", 32'(n_rej), 32'd1);
        check("timeout_cycles", 32'(n_count), 32'd1000);
        check("timeout_no_dis", 32'(n_dis), 32'd0);
        check("timeout_no_up", 32'(n_up), 32'd0);
        check("timeout_idle", 32'(busy), 32'd0);
        sen1 = 1'b0;
        repeat (5) step();

        // lone sen2 edge is ignored
        clear_counts();
        sen2 = 1'b1;
        repeat (12) step();
        check("lone_sen2_busy", 32'(n_busy), 32'd0);
        check("lone_sen2_count", 32'(n_count), 32'd0);
        sen2 = 1'b0;
        repeat (5) step();

        // exit with vehicles present
        clear_counts();
        num_veh = 2'd2;
        sen_exit = 1'b1;
        repeat (6) step();
        sen_exit = 1'b0;
        repeat (3) step();
        check("exit_nv2_down", 32'(n_down), 32'd1);

        // exit with empty lot
        clear_counts();
        num_veh = 2'd0;
        sen_exit = 1'b1;
        repeat (6) step();
        sen_exit = 1'b0;
        repeat (3) step();
        check("exit_nv0_down", 32'(n_down), 32'd0);

        // exit edge lined up with the admit cycle
        run_vehicle(50, 14'd40, 2'd1, 2, 1'b1);
        check("collide_up", 32'(n_up), 32'd1);
        check("collide_down", 32'(n_down), 32'd1);
        check("collide_same_cycle", 32'(n_both), 32'd1);

        // reset in the middle of OPEN
        clear_counts();
        sen1 = 1'b1;
        repeat (30) step();
        sen2 = 1'b1;
        guard = 0;
        while (!cal && guard < 50) begin
            step();
            guard++;
        end
        done = 1'b1;
        speed = 14'd40;
        num_veh = 2'd0;
        guard = 0;
        while (!en && guard < 20) begin
            step();
            guard++;
        end
        repeat (5) step();
        check("open_before_reset", 32'(en), 32'd1);
        reset_n = 1'b1;
        step();
        check("midreset_en", 32'(en), 32'd0);
        check("midreset_all_zero", 32'({init, count, cal, up, down, en, dis, reject, busy}), 32'd0);
        reset_n = 1'b0;
        sen1 = 1'b0;
        sen2 = 1'b0;
        done = 1'b0;
        step();
        check("midreset_idle_init", 32'(init), 32'd1);
        check("midreset_idle_busy", 32'(busy), 32'd0);
        repeat (25) step();
        check("midreset_stays_closed", 32'(en), 32'd0);

        check("en_dis_never_both", 32'(n_endis_total), 32'd0);
        check("up_never_when_full", 32'(n_up_full_total), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
